// File: rtl/fetch_issue_if.sv
// Handshake bundle between the IF stage / EX stage environment and the fetch-issue controller.
// The controller attaches through the slave modport; the surrounding pipeline drives the master side.
interface fetch_issue_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instruction;
  logic [31:0]      PC_reg_out;
  logic             ex_redirect;
  logic             stall_req;
  logic             cnt_clr;
  logic [1:0]       PC_sel;
  logic             should_br;
  logic [31:0]      ex_inst;
  logic [31:0]      ex_pc;
  logic             ex_valid;
  logic             ill_inst;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  modport master (
    output instruction, PC_reg_out, ex_redirect, stall_req, cnt_clr,
    input  PC_sel, should_br, ex_inst, ex_pc, ex_valid, ill_inst, cycle_cnt, inst_cnt
  );

  modport slave (
    input  instruction, PC_reg_out, ex_redirect, stall_req, cnt_clr,
    output PC_sel, should_br, ex_inst, ex_pc, ex_valid, ill_inst, cycle_cnt, inst_cnt
  );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue controller: steers the IF PC mux, squashes fetched words, and owns the IF->EX
// register with stall, redirect-bubble handling and cycle/instruction counters.
module fetch_issue_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input logic          clk,
  input logic          rst,
  fetch_issue_if.slave bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_RESET = 2'd0;
  localparam logic [1:0] SEL_HOLD  = 2'd1;
  localparam logic [1:0] SEL_PC4   = 2'd2;
  localparam logic [1:0] SEL_ALU   = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       pc_sel;
  logic             squash;
  logic             bubble;
  logic             issue_vld;

  logic [31:0]      ex_inst_q;
  logic [31:0]      ex_pc_q;
  logic             ex_valid_q;
  logic             ill_inst_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] inst_cnt_q;

  // RISC-V base encodings always carry 2'b11 in the low bits; anything else is a compressed or bogus word.
  function automatic logic is_illegal(input logic [31:0] word);
    return word[1:0] != 2'b11;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // PC steering is purely a function of state and the EX-side requests, never of the EX registers.
  always_comb begin
    state_d = RUN;
    pc_sel  = SEL_PC4;
    squash  = 1'b0;
    bubble  = 1'b0;
    if (rst || state_q == BOOT) begin
      pc_sel = SEL_RESET;
      squash = 1'b1;
      bubble = 1'b1;
    end else if (bus.ex_redirect) begin
      pc_sel = SEL_ALU;
      squash = 1'b1;
      bubble = 1'b1;
    end else if (bus.stall_req) begin
      pc_sel = SEL_HOLD;
      bubble = 1'b1;
    end
  end

  // A zero word is left over from a squash and is issued as a bubble rather than flagged illegal.
  assign issue_vld = !bubble && (bus.instruction != 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_inst_q   <= NOP_INST;
      ex_pc_q     <= RESET_PC;
      ex_valid_q  <= 1'b0;
      ill_inst_q  <= 1'b0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      ex_inst_q  <= issue_vld ? bus.instruction : NOP_INST;
      ex_pc_q    <= bus.PC_reg_out;
      ex_valid_q <= issue_vld;
      ill_inst_q <= issue_vld && is_illegal(bus.instruction);
      if (bus.cnt_clr) begin
        cycle_cnt_q <= '0;
        inst_cnt_q  <= '0;
      end else begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        inst_cnt_q  <= inst_cnt_q + CNT_W'(issue_vld);
      end
    end
  end

  assign bus.PC_sel    = pc_sel;
  assign bus.should_br = squash;
  assign bus.ex_inst   = ex_inst_q;
  assign bus.ex_pc     = ex_pc_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ill_inst  = ill_inst_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.inst_cnt  = inst_cnt_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Bench for fetch_issue_ctrl: directed vector table, counter-wrap sequences, then random traffic
// compared against a cycle-level behavioural model of the issue rules.
module tb_fetch_issue_ctrl;
  localparam int          CW  = 8;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_issue_if #(.CNT_W(CW)) bus ();
  fetch_issue_ctrl #(.RESET_PC(RPC), .NOP_INST(NOP), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        redir;
    logic        stall;
    logic        clr;
    logic [1:0]  sel;
    logic        br;
    logic        vld;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        ill;
    int          icnt;
    int          ccnt;
  } vec_t;

  vec_t tbl [16];

  // Behavioural model: "booting" means the first cycle after reset, where everything is squashed.
  bit          m_boot = 1'b1;
  logic [31:0] m_inst = NOP;
  logic [31:0] m_pc   = RPC;
  logic        m_vld  = 1'b0;
  logic        m_ill  = 1'b0;
  int          m_cc   = 0;
  int          m_ic   = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] i, input logic [31:0] p,
                              input logic rd, input logic st, input logic cl,
                              input logic [1:0] s, input logic b, input logic v,
                              input logic [31:0] ei, input logic [31:0] ep, input logic il,
                              input int ic, input int cc);
    vec_t t;
    t.rst = r; t.instr = i; t.pc = p; t.redir = rd; t.stall = st; t.clr = cl;
    t.sel = s; t.br = b; t.vld = v; t.einst = ei; t.epc = ep; t.ill = il;
    t.icnt = ic; t.ccnt = cc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] p,
                       input logic rd, input logic st, input logic cl);
    rst             = r;
    bus.instruction = i;
    bus.PC_reg_out  = p;
    bus.ex_redirect = rd;
    bus.stall_req   = st;
    bus.cnt_clr     = cl;
    #1;
  endtask

  function automatic logic [1:0] m_sel();
    if (rst || m_boot)       return 2'd0;
    if (bus.ex_redirect)     return 2'd3;
    if (bus.stall_req)       return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic m_br();
    return rst || m_boot || bus.ex_redirect;
  endfunction

  task automatic model_edge();
    bit issued;
    if (rst) begin
      m_boot = 1'b1; m_inst = NOP; m_pc = RPC; m_vld = 1'b0; m_ill = 1'b0;
      m_cc = 0; m_ic = 0;
    end else begin
      issued = !m_boot && !bus.ex_redirect && !bus.stall_req && (bus.instruction != 0);
      m_inst = issued ? bus.instruction : NOP;
      m_pc   = bus.PC_reg_out;
      m_vld  = issued;
      m_ill  = issued && (bus.instruction[1:0] != 2'b11);
      if (bus.cnt_clr) begin
        m_cc = 0; m_ic = 0;
      end else begin
        m_cc = (m_cc + 1) % (1 << CW);
        m_ic = (m_ic + int'(issued)) % (1 << CW);
      end
      m_boot = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_ex_inst"},   bus.ex_inst,          m_inst);
    chk({tag, "_ex_pc"},     bus.ex_pc,            m_pc);
    chk({tag, "_ex_valid"},  32'(bus.ex_valid),    32'(m_vld));
    chk({tag, "_ill_inst"},  32'(bus.ill_inst),    32'(m_ill));
    chk({tag, "_cycle_cnt"}, 32'(bus.cycle_cnt),   32'(m_cc));
    chk({tag, "_inst_cnt"},  32'(bus.inst_cnt),    32'(m_ic));
  endtask

  task automatic run_to_ff(input string tag);
    logic [31:0] pc;
    pc = 32'h1000;
    for (int k = 0; k < 600 && bus.inst_cnt != 8'hFF; k++) begin
      drive(1'b0, 32'h00108093, pc, 1'b0, 1'b0, 1'b0);
      tick();
      pc = pc + 32'd4;
    end
    chk({tag, "_reach_ff"}, 32'(bus.inst_cnt), 32'h0000_00FF);
  endtask

  initial begin
    bus.instruction = '0; bus.PC_reg_out = '0; bus.ex_redirect = 1'b0;
    bus.stall_req = 1'b0; bus.cnt_clr = 1'b0;

    tbl[0]  = mk(1, 32'h0,        32'h0,   0, 0, 0, 2'd0, 1, 0, NOP,          32'h0,   0, 0, 0);
    tbl[1]  = mk(0, 32'h0,        32'h0,   0, 0, 0, 2'd0, 1, 0, NOP,          32'h0,   0, 0, 1);
    tbl[2]  = mk(0, 32'h00500093, 32'h0,   0, 0, 0, 2'd2, 0, 1, 32'h00500093, 32'h0,   0, 1, 2);
    tbl[3]  = mk(0, 32'h00A00113, 32'h4,   0, 0, 0, 2'd2, 0, 1, 32'h00A00113, 32'h4,   0, 2, 3);
    tbl[4]  = mk(0, 32'h0040006F, 32'h8,   1, 0, 0, 2'd3, 1, 0, NOP,          32'h8,   0, 2, 4);
    tbl[5]  = mk(0, 32'h00100193, 32'hC,   0, 1, 0, 2'd1, 0, 0, NOP,          32'hC,   0, 2, 5);
    tbl[6]  = mk(0, 32'h00100193, 32'hC,   0, 1, 0, 2'd1, 0, 0, NOP,          32'hC,   0, 2, 6);
    tbl[7]  = mk(0, 32'h00100193, 32'hC,   0, 0, 0, 2'd2, 0, 1, 32'h00100193, 32'hC,   0, 3, 7);
    tbl[8]  = mk(0, 32'h00200213, 32'h10,  0, 0, 0, 2'd2, 0, 1, 32'h00200213, 32'h10,  0, 4, 8);
    tbl[9]  = mk(0, 32'h00300293, 32'h14,  1, 1, 0, 2'd3, 1, 0, NOP,          32'h14,  0, 4, 9);
    tbl[10] = mk(0, 32'hFFFFFFFC, 32'h200, 0, 0, 0, 2'd2, 0, 1, 32'hFFFFFFFC, 32'h200, 1, 5, 10);
    tbl[11] = mk(0, 32'h0,        32'h204, 0, 0, 0, 2'd2, 0, 0, NOP,          32'h204, 0, 5, 11);
    tbl[12] = mk(0, 32'h00300293, 32'h208, 0, 1, 0, 2'd1, 0, 0, NOP,          32'h208, 0, 5, 12);
    tbl[13] = mk(1, 32'h00300293, 32'h208, 1, 1, 0, 2'd0, 1, 0, NOP,          RPC,     0, 0, 0);
    tbl[14] = mk(0, 32'h0,        32'h0,   1, 1, 0, 2'd0, 1, 0, NOP,          32'h0,   0, 0, 1);
    tbl[15] = mk(0, 32'h00500093, 32'h0,   0, 0, 1, 2'd2, 0, 1, 32'h00500093, 32'h0,   0, 0, 0);

    foreach (tbl[n]) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      drive(tbl[n].rst, tbl[n].instr, tbl[n].pc, tbl[n].redir, tbl[n].stall, tbl[n].clr);
      chk({tag, "_PC_sel"},    32'(bus.PC_sel),    32'(tbl[n].sel));
      chk({tag, "_should_br"}, 32'(bus.should_br), 32'(tbl[n].br));
      tick();
      chk({tag, "_ex_valid"},  32'(bus.ex_valid),  32'(tbl[n].vld));
      chk({tag, "_ex_inst"},   bus.ex_inst,        tbl[n].einst);
      chk({tag, "_ex_pc"},     bus.ex_pc,          tbl[n].epc);
      chk({tag, "_ill_inst"},  32'(bus.ill_inst),  32'(tbl[n].ill));
      chk({tag, "_inst_cnt"},  32'(bus.inst_cnt),  32'(tbl[n].icnt));
      chk({tag, "_cycle_cnt"}, 32'(bus.cycle_cnt), 32'(tbl[n].ccnt));
    end

    // Clear at full scale must win over the increment.
    run_to_ff("clr");
    drive(1'b0, 32'h00108093, 32'h3000, 1'b0, 1'b0, 1'b1);
    tick();
    chk("clr_at_ff_inst_cnt",  32'(bus.inst_cnt),  32'h0);
    chk("clr_at_ff_cycle_cnt", 32'(bus.cycle_cnt), 32'h0);

    // Natural wrap of the instruction counter.
    run_to_ff("wrap");
    drive(1'b0, 32'h00108093, 32'h4000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_inst_cnt", 32'(bus.inst_cnt), 32'h0);
    chk_model("wrap");

    for (int c = 0; c < 500; c++) begin
      logic [31:0] ins;
      logic [31:0] pc;
      string       tag;
      tag = $sformatf("rnd%0d", c);
      case ($urandom_range(7))
        0:       ins = 32'h0;
        1:       ins = $urandom();
        default: ins = {$urandom() >> 2, 2'b11};
      endcase
      pc = {$urandom_range(32'h3FFF), 2'b00};
      drive($urandom_range(49) == 0, ins, pc, $urandom_range(5) == 0,
            $urandom_range(4) == 0, $urandom_range(39) == 0);
      chk({tag, "_PC_sel"},    32'(bus.PC_sel),    32'(m_sel()));
      chk({tag, "_should_br"}, 32'(bus.should_br), 32'(m_br()));
      tick();
      chk_model(tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
